cmd_receiver: RTL
=================

Name: cmd_receiver

Overview:
- Device-side end of the remote command link; sits between the existing 8-bit UART transceiver and the command processor.
- Assembles two received bytes, high byte first, into one 16-bit command and presents it with a ready flag.
- Sends the processor's 8-bit response back over the UART.
- Discards partial commands whose low byte does not arrive within a timeout.

Parameters:
- TIMEOUT_CLKS, default 100000: maximum clocks allowed between the high byte and the low byte before the partial command is discarded.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset: synchronous, active-high. Single clock domain.
- rx_data  in  8  received byte from UART.
- rx_rdy  in  1  UART byte available. Held high until cleared.
- clr_rx_rdy  out  1  one-cycle pulse: byte consumed.
- tx_data  out  8  byte to UART transmitter.
- trmt  out  1  one-cycle pulse: start UART transmit.
- tx_done  in  1  UART transmit complete.
- cmd  out  16  last complete command, as {high byte, low byte}.
- cmd_rdy  out  1  new command available.
- clr_cmd_rdy  in  1  processor acknowledges the command.
- resp  in  8  response byte from the processor.
- send_resp  in  1  request to transmit resp.
- resp_sent  out  1  response transmission complete.
- timeout_err  out  1  one-cycle pulse: partial command discarded.

Behaviour:
- Reset values: all outputs 0 (cmd=16'h0000, tx_data=8'h00). Both FSMs go to their idle states.
- Reset mid-operation: a partial command or pending response is discarded, and no trmt is issued afterward.
- All outputs are registered.
- UART contract: the UART clears rx_rdy on the same edge that samples clr_rx_rdy. The block consumes exactly one byte per rx_rdy assertion.

RX FSM:
- RX_HIGH, rx_rdy=1:
  - cmd_hi <= rx_data; pulse clr_rx_rdy; cmd_rdy <= 0; timer <= 0.
  - Next state RX_LOW.
- RX_LOW, rx_rdy=1:
  - cmd <= {cmd_hi, rx_data}; pulse clr_rx_rdy; cmd_rdy <= 1.
  - Next state RX_HIGH. cmd and cmd_rdy are visible the cycle after the sampling edge.
- RX_LOW, no byte:
  - timer increments each clock.
  - When timer == TIMEOUT_CLKS-1: pulse timeout_err, return to RX_HIGH, leave cmd and cmd_rdy unchanged.
- rx_rdy coinciding with timeout expiry: the byte wins and the command completes. No error.
- cmd holds stable until the next complete command.
- cmd_rdy clears on clr_cmd_rdy or on the arrival of a new high byte.
- clr_cmd_rdy in the same cycle as completion: set wins.
- Timer width: $clog2(TIMEOUT_CLKS). It does not count in RX_HIGH.

TX FSM:
- TX_IDLE, send_resp=1:
  - tx_data <= resp; trmt <= 1 for one cycle; resp_sent <= 0.
  - Next state TX_BUSY.
- TX_BUSY, send_resp=1:
  - resp goes into a one-deep pending slot. A later request overwrites the slot (latest wins).
  - resp_sent <= 0.
- TX_BUSY, tx_done=1, pending slot full:
  - tx_data <= pending byte; pulse trmt; clear the slot; stay in TX_BUSY.
- TX_BUSY, tx_done=1, slot empty:
  - resp_sent <= 1; next state TX_IDLE.
- send_resp in the same cycle as tx_done with slot empty:
  - The new byte is transmitted immediately (trmt pulse); resp_sent stays 0.
- resp_sent clears on send_resp.
- RX and TX paths are fully independent. Simultaneous activity on both is legal.

Decomposition:
- Package cmd_rx_pkg holds:
  - rx_state_t {RX_HIGH, RX_LOW}
  - tx_state_t {TX_IDLE, TX_BUSY}
  - CMD_W=16 and BYTE_W=8
- One sub-module, resp_tx: the TX FSM with its pending slot, tx_data register, trmt and resp_sent.
- Byte assembly and timeout stay in cmd_receiver.

Test Plan:
- Bytes 8'hA5 then 8'h3C on rx_rdy -> two clr_rx_rdy pulses; cmd=16'hA53C and cmd_rdy=1 the cycle after the second byte; clr_cmd_rdy -> cmd_rdy=0, cmd unchanged.
- High byte 8'h12, no low byte (TIMEOUT_CLKS=50) -> timeout_err pulse exactly 50 clocks later; then 8'h34, 8'h56 -> cmd=16'h3456, not 16'h1234 or 16'h1256.
- Low byte rx_rdy on the expiry cycle -> command completes, no timeout_err. Separately, clr_cmd_rdy coinciding with completion -> cmd_rdy=1.
- send_resp with resp=8'hA5 -> trmt one cycle later with tx_data=8'hA5; tx_done -> resp_sent=1. Second send_resp -> resp_sent drops.
- send_resp 8'h11 then 8'h22 and 8'h33 while busy -> transmit sequence 8'h11, 8'h33; resp_sent only after the final tx_done.
- rst asserted between the high and low byte and during TX_BUSY -> all outputs 0 the next cycle; a following 16'hBEEF command is received correctly and no stale trmt appears.

Source files
------------

// File: rtl/cmd_rx_pkg.sv
// -----------------------------------------------------------------------------
// cmd_rx_pkg
// Shared types and widths for the remote command link receiver.
//   rx_state_t : command assembly FSM states (high byte / low byte)
//   tx_state_t : response transmit FSM states (idle / busy)
//   CMD_W      : width of an assembled command
//   BYTE_W     : width of a UART byte
// -----------------------------------------------------------------------------
package cmd_rx_pkg;

  localparam int CMD_W  = 16;
  localparam int BYTE_W = 8;

  typedef enum logic {
    RX_HIGH = 1'b0,
    RX_LOW  = 1'b1
  } rx_state_t;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_BUSY = 1'b1
  } tx_state_t;

endpackage : cmd_rx_pkg

// File: rtl/resp_tx.sv
// -----------------------------------------------------------------------------
// resp_tx
// Sends the command processor's response bytes to the UART transmitter.
// A request arriving while a byte is on the wire is parked in a one-deep
// pending slot; later requests overwrite it, so only the newest response
// waiting behind the current transmission is sent.
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   resp       : response byte from the processor
//   send_resp  : request to transmit resp (sampled each clock)
//   tx_done    : UART reports the current byte has been sent
//   tx_data    : byte handed to the UART (registered)
//   trmt       : one-cycle pulse, UART starts sending tx_data
//   resp_sent  : level, all requested responses have left the UART
//
// Handshake: send_resp/tx_done are single-cycle strobes; each strobe is
// acted on exactly once on the clock edge that samples it. trmt is a
// single-cycle strobe to the UART with tx_data stable from that edge on.
// -----------------------------------------------------------------------------
module resp_tx
  import cmd_rx_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] resp,
  input  logic              send_resp,
  input  logic              tx_done,
  output logic [BYTE_W-1:0] tx_data,
  output logic              trmt,
  output logic              resp_sent
);

  tx_state_t         tx_state;
  logic              pend_valid;
  logic [BYTE_W-1:0] pend_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state   <= TX_IDLE;
      pend_valid <= 1'b0;
      pend_data  <= '0;
      tx_data    <= '0;
      trmt       <= 1'b0;
      resp_sent  <= 1'b0;
    end else begin
      trmt <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          if (send_resp) begin
            tx_data   <= resp;
            trmt      <= 1'b1;
            resp_sent <= 1'b0;
            tx_state  <= TX_BUSY;
          end
        end

        TX_BUSY: begin
          if (tx_done) begin
            if (pend_valid) begin
              // Launch the parked byte; a request in this same cycle
              // refills the slot so it is not lost.
              tx_data    <= pend_data;
              trmt       <= 1'b1;
              pend_valid <= send_resp;
              if (send_resp) begin
                pend_data <= resp;
                resp_sent <= 1'b0;
              end
            end else if (send_resp) begin
              // Back-to-back request: go straight out, no idle turnaround.
              tx_data   <= resp;
              trmt      <= 1'b1;
              resp_sent <= 1'b0;
            end else begin
              resp_sent <= 1'b1;
              tx_state  <= TX_IDLE;
            end
          end else if (send_resp) begin
            pend_data  <= resp;
            pend_valid <= 1'b1;
            resp_sent  <= 1'b0;
          end
        end

        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule : resp_tx

// File: rtl/cmd_receiver.sv
// -----------------------------------------------------------------------------
// cmd_receiver
// Device-side end of the remote command link. Assembles two UART bytes
// (high byte first) into a 16-bit command for the command processor and
// returns the processor's response bytes over the UART via resp_tx.
// A high byte whose low byte does not follow within TIMEOUT_CLKS clocks is
// dropped and reported with timeout_err.
//
// Parameters:
//   TIMEOUT_CLKS : clocks allowed between high and low byte
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   rx_data      : received byte from the UART
//   rx_rdy       : UART byte available (held until clr_rx_rdy is sampled)
//   clr_rx_rdy   : one-cycle pulse, byte consumed
//   tx_data      : byte to the UART transmitter
//   trmt         : one-cycle pulse, start UART transmit
//   tx_done      : UART transmit complete
//   cmd          : last complete command {high, low}
//   cmd_rdy      : new command available
//   clr_cmd_rdy  : processor acknowledges the command
//   resp         : response byte from the processor
//   send_resp    : request to transmit resp
//   resp_sent    : response transmission complete
//   timeout_err  : one-cycle pulse, partial command discarded
//
// Handshake: the UART holds rx_rdy until the edge that samples clr_rx_rdy
// and drops it on that edge, so during the cycle clr_rx_rdy is high the
// old byte is still flagged; it must not be taken a second time.
// cmd_rdy is a level held until clr_cmd_rdy or a new high byte; a
// completion in the same cycle as clr_cmd_rdy leaves it set.
// -----------------------------------------------------------------------------
module cmd_receiver
  import cmd_rx_pkg::*;
#(
  parameter int TIMEOUT_CLKS = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_rdy,
  output logic              clr_rx_rdy,
  output logic [BYTE_W-1:0] tx_data,
  output logic              trmt,
  input  logic              tx_done,
  output logic [CMD_W-1:0]  cmd,
  output logic              cmd_rdy,
  input  logic              clr_cmd_rdy,
  input  logic [BYTE_W-1:0] resp,
  input  logic              send_resp,
  output logic              resp_sent,
  output logic              timeout_err
);

  localparam int TMR_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CLKS - 1);

  rx_state_t         rx_state;
  logic [BYTE_W-1:0] cmd_hi;
  logic [TMR_W-1:0]  timer;
  logic              byte_avail;

  // Mask the cycle where our own clear is in flight (see handshake note).
  assign byte_avail = rx_rdy && !clr_rx_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state    <= RX_HIGH;
      cmd_hi      <= '0;
      timer       <= '0;
      cmd         <= '0;
      cmd_rdy     <= 1'b0;
      clr_rx_rdy  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      clr_rx_rdy  <= 1'b0;
      timeout_err <= 1'b0;
      // Acknowledge first so that a completion below overrides it.
      if (clr_cmd_rdy) cmd_rdy <= 1'b0;

      case (rx_state)
        RX_HIGH: begin
          if (byte_avail) begin
            cmd_hi     <= rx_data;
            clr_rx_rdy <= 1'b1;
            cmd_rdy    <= 1'b0;
            timer      <= '0;
            rx_state   <= RX_LOW;
          end
        end

        RX_LOW: begin
          // A byte on the expiry cycle takes priority over the timeout.
          if (byte_avail) begin
            cmd        <= {cmd_hi, rx_data};
            clr_rx_rdy <= 1'b1;
            cmd_rdy    <= 1'b1;
            rx_state   <= RX_HIGH;
          end else if (timer == TMR_LAST) begin
            timeout_err <= 1'b1;
            rx_state    <= RX_HIGH;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        default: rx_state <= RX_HIGH;
      endcase
    end
  end

  resp_tx u_resp_tx (
    .clk       (clk),
    .rst       (rst),
    .resp      (resp),
    .send_resp (send_resp),
    .tx_done   (tx_done),
    .tx_data   (tx_data),
    .trmt      (trmt),
    .resp_sent (resp_sent)
  );

endmodule : cmd_receiver
